// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM, one state per clock, 3-5 cycles per instruction.
// FETCH and MEMRD stall while mem_ready is low (ignored when MEM_HANDSHAKE=0).
module mips_multicycle_ctrl #(
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [3:0] state,
  output logic       iord,
  output logic       alu_src_a,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       pc_en
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t cur_state;
  state_t nxt_state;
  logic   ready;

  assign ready = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
  assign state = cur_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_state <= FETCH;
    end else begin
      cur_state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state = FETCH;
    case (cur_state)
      FETCH:    nxt_state = ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt_state = MEMADR;
          OP_RTYPE:     nxt_state = EXECUTE;
          OP_BEQ:       nxt_state = BRANCH;
          OP_ADDI:      nxt_state = ADDIEXEC;
          OP_J:         nxt_state = JUMP;
          default:      nxt_state = FETCH;
        endcase
      end
      // op is re-examined here; anything other than LW/SW abandons the access
      MEMADR: begin
        if (op == OP_LW) begin
          nxt_state = MEMRD;
        end else if (op == OP_SW) begin
          nxt_state = MEMWR;
        end else begin
          nxt_state = FETCH;
        end
      end
      MEMRD:    nxt_state = ready ? MEMWB : MEMRD;
      EXECUTE:  nxt_state = ALUWB;
      ADDIEXEC: nxt_state = ADDIWB;
      MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP: nxt_state = FETCH;
      default:  nxt_state = FETCH;
    endcase
  end

  always_comb begin
    iord       = 1'b0;
    alu_src_a  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    alu_op     = 2'b00;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    pc_en      = 1'b0;
    case (cur_state)
      FETCH: begin
        alu_src_b = 2'b01;
        ir_write  = ready;
        pc_en     = ready;
      end
      DECODE:   alu_src_b = 2'b11;
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD:    iord = 1'b1;
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        pc_en     = zero;
      end
      ADDIEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ADDIWB:   reg_write = 1'b1;
      JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
      default: ;
    endcase
    // Reset forces the state to FETCH already; only the enables need masking
    if (!rst) begin
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      pc_en     = 1'b0;
    end
  end

  a_single_write: assert property (@(posedge clk) disable iff (!rst) !(mem_write && reg_write));

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed vector table, reset/handshake sequences, random run vs instruction model.
module tb_mips_multicycle_ctrl;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;

  typedef struct packed {
    logic       iord, alu_src_a, reg_dst, mem_to_reg;
    logic [1:0] alu_src_b, pc_src, alu_op;
    logic       ir_write, mem_write, reg_write, pc_en;
  } ctl_t;

  typedef struct {
    logic [5:0] op;
    logic       zero;
    logic       mr;
    int         st;
    logic [3:0] we;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic       zero, mem_ready;
  logic [3:0] state, nh_state;
  logic       iord, alu_src_a, reg_dst, mem_to_reg;
  logic [1:0] alu_src_b, pc_src, alu_op;
  logic       ir_write, mem_write, reg_write, pc_en;
  logic       nh_iord, nh_alu_src_a, nh_reg_dst, nh_mem_to_reg;
  logic [1:0] nh_alu_src_b, nh_pc_src, nh_alu_op;
  logic       nh_ir_write, nh_mem_write, nh_reg_write, nh_pc_en;

  int n_checks = 0;
  int n_fail = 0;
  vec_t tbl[$];
  int path[$];

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.MEM_HANDSHAKE(1)) u_dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready), .state(state),
    .iord(iord), .alu_src_a(alu_src_a), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_op(alu_op),
    .ir_write(ir_write), .mem_write(mem_write), .reg_write(reg_write), .pc_en(pc_en)
  );

  mips_multicycle_ctrl #(.MEM_HANDSHAKE(0)) u_dut_nh (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready), .state(nh_state),
    .iord(nh_iord), .alu_src_a(nh_alu_src_a), .reg_dst(nh_reg_dst), .mem_to_reg(nh_mem_to_reg),
    .alu_src_b(nh_alu_src_b), .pc_src(nh_pc_src), .alu_op(nh_alu_op),
    .ir_write(nh_ir_write), .mem_write(nh_mem_write), .reg_write(nh_reg_write), .pc_en(nh_pc_en)
  );

  function automatic ctl_t dut_ctl();
    return {iord, alu_src_a, reg_dst, mem_to_reg, alu_src_b, pc_src, alu_op,
            ir_write, mem_write, reg_write, pc_en};
  endfunction

  // Per-state control word as listed in the state/output table of the block
  function automatic ctl_t exp_out(int st, logic mr, logic z);
    ctl_t c = '0;
    case (st)
      0:  begin c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_en = mr; end
      1:  c.alu_src_b = 2'b11;
      2:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      3:  c.iord = 1'b1;
      4:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      5:  begin c.iord = 1'b1; c.mem_write = 1'b1; end
      6:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      7:  begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      8:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.pc_en = z; end
      9:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      10: c.reg_write = 1'b1;
      11: begin c.pc_src = 2'b10; c.pc_en = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

  // State trace of one instruction with no wait cycles
  task automatic build_path(input logic [5:0] o);
    path = {};
    path.push_back(0);
    path.push_back(1);
    case (o)
      LW:      begin path.push_back(2); path.push_back(3); path.push_back(4); end
      SW:      begin path.push_back(2); path.push_back(5); end
      RT:      begin path.push_back(6); path.push_back(7); end
      BEQ:     path.push_back(8);
      ADDI:    begin path.push_back(9); path.push_back(10); end
      J:       path.push_back(11);
      default: ;
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic add(input logic [5:0] o, input logic z, input logic mr, input int st,
                     input logic [3:0] we);
    vec_t v;
    v.op = o; v.zero = z; v.mr = mr; v.st = st; v.we = we;
    tbl.push_back(v);
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] r;
    case ($urandom_range(0, 6))
      0: r = LW;
      1: r = SW;
      2: r = RT;
      3: r = BEQ;
      4: r = ADDI;
      5: r = J;
      default: r = 6'($urandom);
    endcase
    return r;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_nh[5];
    ctl_t c;
    logic [5:0] cur_op;
    int idx;
    int st;

    // LW, SW, BEQ taken/not taken, J, FETCH waits + RTYPE, illegal op, ADDI, LW with MEMRD waits
    add(LW, 0, 1, 0, 4'b1001); add(LW, 0, 1, 1, 4'b0000); add(LW, 0, 1, 2, 4'b0000);
    add(LW, 0, 1, 3, 4'b0000); add(LW, 0, 1, 4, 4'b0010);
    add(SW, 0, 1, 0, 4'b1001); add(SW, 0, 1, 1, 4'b0000); add(SW, 0, 1, 2, 4'b0000);
    add(SW, 0, 1, 5, 4'b0100);
    add(BEQ, 1, 1, 0, 4'b1001); add(BEQ, 1, 1, 1, 4'b0000); add(BEQ, 1, 1, 8, 4'b0001);
    add(BEQ, 0, 1, 0, 4'b1001); add(BEQ, 0, 1, 1, 4'b0000); add(BEQ, 0, 1, 8, 4'b0000);
    add(J, 0, 1, 0, 4'b1001); add(J, 0, 1, 1, 4'b0000); add(J, 0, 1, 11, 4'b0001);
    add(RT, 0, 0, 0, 4'b0000); add(RT, 0, 0, 0, 4'b0000); add(RT, 0, 0, 0, 4'b0000);
    add(RT, 0, 1, 0, 4'b1001); add(RT, 0, 1, 1, 4'b0000); add(RT, 0, 1, 6, 4'b0000);
    add(RT, 0, 1, 7, 4'b0010);
    add(BAD, 0, 1, 0, 4'b1001); add(BAD, 0, 1, 1, 4'b0000);
    add(ADDI, 0, 1, 0, 4'b1001); add(ADDI, 0, 1, 1, 4'b0000); add(ADDI, 0, 1, 9, 4'b0000);
    add(ADDI, 0, 1, 10, 4'b0010);
    add(LW, 0, 1, 0, 4'b1001); add(LW, 0, 1, 1, 4'b0000); add(LW, 0, 1, 2, 4'b0000);
    add(LW, 0, 0, 3, 4'b0000); add(LW, 0, 0, 3, 4'b0000); add(LW, 0, 1, 3, 4'b0000);
    add(LW, 0, 1, 4, 4'b0010);
    add(BAD, 0, 0, 0, 4'b0000);

    rst = 1'b0; op = RT; zero = 1'b0; mem_ready = 1'b1;
    #2;
    check("reset_state", state, 0);
    check("reset_ctl", dut_ctl(), exp_out(0, 1'b0, 1'b0));
    check("reset_nh_pc_en", nh_pc_en, 0);

    @(negedge clk);
    check("reset_hold_across_edge", state, 0);
    rst = 1'b1; op = LW; mem_ready = 1'b0;
    #1;
    check("fetch_wait_ir_write", ir_write, 0);
    check("nh_fetch_ir_pc", {nh_ir_write, nh_pc_en}, 2'b11);
    exp_nh = '{1, 2, 3, 4, 0};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      check("nh_lw_state", nh_state, exp_nh[k]);
      check("hs_fetch_hold", state, 0);
    end

    foreach (tbl[i]) begin
      @(negedge clk);
      op = tbl[i].op; zero = tbl[i].zero; mem_ready = tbl[i].mr;
      #1;
      c = dut_ctl();
      check($sformatf("vec%0d_state", i), state, tbl[i].st);
      check($sformatf("vec%0d_we", i), {c.ir_write, c.mem_write, c.reg_write, c.pc_en}, tbl[i].we);
      check($sformatf("vec%0d_ctl", i), c, exp_out(tbl[i].st, tbl[i].mr, tbl[i].zero));
    end

    // Reset asserted between edges while a store is in MEMWR
    exp_nh = '{0, 1, 2, 5, 0};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      op = SW; mem_ready = 1'b1; zero = 1'b0;
      #1;
      check("sw_state", state, exp_nh[k]);
    end
    #1 rst = 1'b0;
    #1;
    check("midrst_state", state, 0);
    check("midrst_mem_write", mem_write, 0);
    check("midrst_ctl", dut_ctl(), exp_out(0, 1'b0, 1'b0));
    @(negedge clk);
    check("midrst_hold", state, 0);
    rst = 1'b1; op = J;
    #1;
    check("post_rst_fetch", dut_ctl(), exp_out(0, 1'b1, 1'b0));
    exp_nh = '{1, 11, 0, 0, 0};
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      check("post_rst_j_state", state, exp_nh[k]);
      check("post_rst_j_ctl", dut_ctl(), exp_out(exp_nh[k], 1'b1, 1'b0));
    end

    // Random instruction stream; op is noise outside DECODE/MEMADR
    cur_op = pick_op();
    build_path(cur_op);
    idx = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      st = path[idx];
      op = (st == 1 || st == 2) ? cur_op : 6'($urandom);
      mem_ready = ($urandom_range(0, 3) != 0);
      zero = 1'($urandom_range(0, 1));
      #1;
      check("rnd_state", state, st);
      check("rnd_ctl", dut_ctl(), exp_out(st, mem_ready, zero));
      check("rnd_single_write", mem_write & reg_write, 0);
      if (!((st == 0 || st == 3) && !mem_ready)) idx++;
      if (idx == path.size()) begin
        cur_op = pick_op();
        build_path(cur_op);
        idx = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
